// File: rtl/turbo_enc_crsc_pkg.sv
// Shared types, trellis arithmetic and circulation-state table for the
// duobinary CRSC constituent encoder.
package turbo_enc_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] trellis_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRE,
    ST_CIRC,
    ST_ENC,
    ST_DONE
  } fsm_state_t;

  typedef struct packed {
    trellis_state_t next;
    logic           y;
    logic           w;
  } trellis_out_t;

  // Indexed [N mod 7][S0N]; row 0 is never used because such blocks are rejected.
  localparam trellis_state_t CIRC [7][8] = '{
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd6, 3'd4, 3'd2, 3'd7, 3'd1, 3'd3, 3'd5},
    '{3'd0, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6, 3'd2, 3'd1},
    '{3'd0, 3'd5, 3'd3, 3'd6, 3'd2, 3'd7, 3'd1, 3'd4},
    '{3'd0, 3'd4, 3'd1, 3'd5, 3'd6, 3'd2, 3'd7, 3'd3},
    '{3'd0, 3'd2, 3'd5, 3'd7, 3'd1, 3'd3, 3'd4, 3'd6},
    '{3'd0, 3'd7, 3'd6, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2}
  };

  // State is {s1,s2,s3}; pair is {A,B}.
  function automatic trellis_out_t trellis_step(input trellis_state_t s, input logic [1:0] ab);
    trellis_out_t r;
    logic         fb;
    fb     = ab[1] ^ ab[0] ^ s[2] ^ s[0];
    r.y    = fb ^ s[1] ^ s[0];
    r.w    = fb ^ s[0];
    r.next = {fb, s[2] ^ ab[0], s[1] ^ ab[0]};
    return r;
  endfunction

endpackage

// File: rtl/turbo_enc_crsc_if.sv
// Pair-input / encoded-output bus of the CRSC encoder.
interface turbo_enc_crsc_if #(
  parameter int unsigned MAX_BLOCK_WIDTH = 10
);
  logic [MAX_BLOCK_WIDTH-1:0] i_block_size;
  logic [1:0]                 i_siso_data_ab;
  logic                       i_siso_buf_wr;
  logic                       i_out_ready;
  logic [1:0]                 o_enc_ab;
  logic [1:0]                 o_enc_yw;
  logic                       o_enc_valid;
  logic                       o_enc_done;
  logic                       o_busy;
  logic                       o_err;

  modport master (
    output i_block_size, i_siso_data_ab, i_siso_buf_wr, i_out_ready,
    input  o_enc_ab, o_enc_yw, o_enc_valid, o_enc_done, o_busy, o_err
  );

  modport slave (
    input  i_block_size, i_siso_data_ab, i_siso_buf_wr, i_out_ready,
    output o_enc_ab, o_enc_yw, o_enc_valid, o_enc_done, o_busy, o_err
  );
endinterface

// File: rtl/turbo_enc_crsc_pair_ram.sv
// Simple dual-port pair buffer: synchronous write, registered 1-cycle read.
module turbo_enc_pair_ram #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [1:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [1:0]        rdata_o
);
  logic [1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/turbo_enc_crsc.sv
// Duobinary CRSC constituent encoder: buffers a block of AB pairs, pre-encodes
// to find the circulation state, then re-encodes from it onto a valid/ready output.
module turbo_enc_crsc
  import turbo_enc_pkg::*;
#(
  parameter int unsigned MAX_BLOCK_WIDTH = 10,
  parameter int unsigned MAX_DATA_WIDTH  = MAX_BLOCK_WIDTH + 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  turbo_enc_crsc_if.slave  bus
);
  localparam int unsigned CW = MAX_DATA_WIDTH + 1;
  typedef logic [CW-1:0] cnt_t;

  fsm_state_t     state_q;
  trellis_state_t s_q;
  logic [2:0]     mod7_q;
  cnt_t           n_q;
  cnt_t           wr_cnt_q;
  cnt_t           rd_cnt_q;
  logic           pf_q;
  logic [1:0]     ab_q;
  logic [1:0]     yw_q;
  logic           valid_q;
  logic           done_q;
  logic           err_q;

  cnt_t                    n_in;
  logic [2:0]              mod7_in;
  logic                    blk_ok;
  logic                    we;
  logic [MAX_DATA_WIDTH-1:0] waddr;
  logic [MAX_DATA_WIDTH-1:0] raddr;
  logic [1:0]              rdata;
  trellis_out_t            step;
  logic                    accept;
  logic                    load;

  always_comb begin
    n_in    = cnt_t'({bus.i_block_size, 2'b00});
    mod7_in = 3'(n_in % cnt_t'(7));
    blk_ok  = (bus.i_block_size != '0) && (mod7_in != '0);
    we      = bus.i_siso_buf_wr && !i_rst &&
              (((state_q == ST_IDLE) && blk_ok) || (state_q == ST_FILL));
    waddr   = (state_q == ST_FILL) ? wr_cnt_q[MAX_DATA_WIDTH-1:0] : '0;
    step    = trellis_step(s_q, rdata);
    accept  = valid_q && bus.i_out_ready;
    // Read address runs one ahead on a load so the RAM output already holds
    // the following pair next cycle: back-to-back beats without a bubble.
    load    = (state_q == ST_ENC) && pf_q && (!valid_q || bus.i_out_ready) &&
              (rd_cnt_q != n_q);
    raddr   = load ? rd_cnt_q[MAX_DATA_WIDTH-1:0] + 1'b1 : rd_cnt_q[MAX_DATA_WIDTH-1:0];
  end

  turbo_enc_pair_ram #(
    .ADDR_W (MAX_DATA_WIDTH)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.i_siso_data_ab),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      mod7_q   <= '0;
      n_q      <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      pf_q     <= 1'b0;
      ab_q     <= '0;
      yw_q     <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.i_siso_buf_wr && !((state_q == ST_IDLE) && blk_ok) && (state_q != ST_FILL))
        err_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_siso_buf_wr && blk_ok) begin
            n_q      <= n_in;
            mod7_q   <= mod7_in;
            wr_cnt_q <= cnt_t'(1);
            s_q      <= '0;
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.i_siso_buf_wr) begin
            wr_cnt_q <= wr_cnt_q + cnt_t'(1);
            if (wr_cnt_q == n_q - cnt_t'(1)) begin
              rd_cnt_q <= '0;
              s_q      <= '0;
              state_q  <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          // rdata holds the pair at rd_cnt_q-1, issued last cycle.
          if (rd_cnt_q != '0) s_q <= step.next;
          if (rd_cnt_q == n_q) state_q  <= ST_CIRC;
          else                 rd_cnt_q <= rd_cnt_q + cnt_t'(1);
        end
        ST_CIRC: begin
          s_q      <= CIRC[mod7_q][s_q];
          rd_cnt_q <= '0;
          pf_q     <= 1'b0;
          state_q  <= ST_ENC;
        end
        ST_ENC: begin
          pf_q <= 1'b1;
          if (load) begin
            ab_q     <= rdata;
            yw_q     <= {step.y, step.w};
            s_q      <= step.next;
            valid_q  <= 1'b1;
            rd_cnt_q <= rd_cnt_q + cnt_t'(1);
          end else if (accept && (rd_cnt_q == n_q)) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_enc_ab    = ab_q;
  assign bus.o_enc_yw    = yw_q;
  assign bus.o_enc_valid = valid_q;
  assign bus.o_enc_done  = done_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_turbo_enc_crsc.sv
// Scoreboard bench for turbo_enc_crsc: expected beats are queued from an
// independent trellis model and popped by a monitor on accepted output beats.
module tb_turbo_enc_crsc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  turbo_enc_crsc_if #(.MAX_BLOCK_WIDTH(10)) bus ();

  turbo_enc_crsc #(
    .MAX_BLOCK_WIDTH (10),
    .MAX_DATA_WIDTH  (12)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] sb_q [$];
  int beat_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_acc = 0;
  int last_acc = 0;
  logic prev_hold = 1'b0;
  logic [4:0] prev_out = '0;
  logic [3:0] mon_exp;

  localparam logic [2:0] M_CIRC [7][8] = '{
    '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
    '{3'd0, 3'd6, 3'd4, 3'd2, 3'd7, 3'd1, 3'd3, 3'd5},
    '{3'd0, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6, 3'd2, 3'd1},
    '{3'd0, 3'd5, 3'd3, 3'd6, 3'd2, 3'd7, 3'd1, 3'd4},
    '{3'd0, 3'd4, 3'd1, 3'd5, 3'd6, 3'd2, 3'd7, 3'd3},
    '{3'd0, 3'd2, 3'd5, 3'd7, 3'd1, 3'd3, 3'd4, 3'd6},
    '{3'd0, 3'd7, 3'd6, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2}
  };

  // Returns {s1',s2',s3',Y,W}.
  function automatic logic [4:0] m_step(input logic [2:0] s, input logic [1:0] ab);
    logic s1, s2, s3, a, b, fb;
    {s1, s2, s3} = s;
    {a, b} = ab;
    fb = a ^ b ^ s1 ^ s3;
    return {fb, s1 ^ b, s2 ^ b, fb ^ s2 ^ s3, fb ^ s3};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if ({bus.o_enc_valid, bus.o_enc_ab, bus.o_enc_yw} !== prev_out) begin
          errors++;
          $display("FAIL hold_stable: got %b required %b", {bus.o_enc_valid, bus.o_enc_ab, bus.o_enc_yw}, prev_out);
        end
      end
      if (bus.o_enc_valid && bus.i_out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got ab/yw=%b required no beat", {bus.o_enc_ab, bus.o_enc_yw});
        end else begin
          mon_exp = sb_q.pop_front();
          if ({bus.o_enc_ab, bus.o_enc_yw} !== mon_exp) begin
            errors++;
            $display("FAIL beat%0d: got ab/yw=%b required %b", beat_cnt, {bus.o_enc_ab, bus.o_enc_yw}, mon_exp);
          end
        end
        if (beat_cnt == 0) first_acc = cyc;
        last_acc = cyc;
        beat_cnt++;
      end
      if (bus.o_enc_done) done_cnt++;
      prev_hold = bus.o_enc_valid && !bus.i_out_ready;
      prev_out  = {bus.o_enc_valid, bus.o_enc_ab, bus.o_enc_yw};
    end
  end

  task automatic model_push(input logic [1:0] pairs [$], output logic [2:0] sc);
    logic [2:0] s;
    logic [4:0] r;
    s = '0;
    foreach (pairs[i]) begin
      r = m_step(s, pairs[i]);
      s = r[4:2];
    end
    sc = M_CIRC[pairs.size() % 7][s];
    s = sc;
    foreach (pairs[i]) begin
      r = m_step(s, pairs[i]);
      sb_q.push_back({pairs[i], r[1:0]});
      s = r[4:2];
    end
  endtask

  task automatic write_pairs(input int bs, input logic [1:0] pairs [$], input bit pre_strobe);
    bus.i_out_ready = 1'b1;
    foreach (pairs[i]) begin
      bus.i_block_size   = 10'(bs);
      bus.i_siso_data_ab = pairs[i];
      bus.i_siso_buf_wr  = 1'b1;
      @(posedge clk); #1;
    end
    bus.i_siso_buf_wr = 1'b0;
    if (pre_strobe) begin
      bus.i_siso_data_ab = 2'b11;
      bus.i_siso_buf_wr  = 1'b1;
      @(posedge clk); #1;
      bus.i_siso_buf_wr  = 1'b0;
    end
  endtask

  task automatic run_block(input string name, input int bs, input logic [1:0] pairs [$],
                           input bit rnd_ready, input bit pre_strobe, input logic [2:0] sc_exp);
    int n;
    int budget;
    n = 4 * bs;
    beat_cnt = 0;
    done_cnt = 0;
    write_pairs(bs, pairs, pre_strobe);
    budget = 3 * n + 50;
    while (done_cnt == 0 && budget > 0) begin
      bus.i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      budget--;
    end
    bus.i_out_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done pulse required one within %0d cycles", name, 3 * n + 50);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_after_done: got %b required 0", name, bus.o_busy);
    end
    checks++;
    if (dut.s_q !== sc_exp) begin
      errors++;
      $display("FAIL %s_final_state: got %0d required %0d", name, dut.s_q, sc_exp);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d required 1", name, done_cnt);
    end
    checks++;
    if (beat_cnt != n) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d required %0d", name, beat_cnt, n);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_beats: got %0d left required 0", name, sb_q.size());
    end
    if (!rnd_ready) begin
      checks++;
      if (last_acc - first_acc + 1 != n) begin
        errors++;
        $display("FAIL %s_throughput: got span %0d required %0d", name, last_acc - first_acc + 1, n);
      end
    end
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.o_enc_ab, bus.o_enc_yw, bus.o_enc_valid, bus.o_enc_done, bus.o_busy, bus.o_err} !== 8'b0) begin
      errors++;
      $display("FAIL %s: got ab,yw,valid,done,busy,err=%b required 00000000", name,
               {bus.o_enc_ab, bus.o_enc_yw, bus.o_enc_valid, bus.o_enc_done, bus.o_busy, bus.o_err});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_known_block();
    logic [1:0] p [$];
    p = {2'b10, 2'b00, 2'b00, 2'b00};
    sb_q.push_back({2'b10, 2'b00});
    sb_q.push_back({2'b00, 2'b01});
    sb_q.push_back({2'b00, 2'b01});
    sb_q.push_back({2'b00, 2'b10});
    run_block("known", 1, p, 1'b0, 1'b0, 3'd5);
  endtask

  task automatic test_zero_block();
    logic [1:0] p [$];
    logic [2:0] sc;
    p = {2'b00, 2'b00, 2'b00, 2'b00};
    model_push(p, sc);
    run_block("zeros", 1, p, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_random_ready();
    logic [1:0] p [$];
    logic [2:0] sc;
    for (int i = 0; i < 8; i++) p.push_back(2'($urandom));
    model_push(p, sc);
    run_block("rnd_ready", 2, p, 1'b1, 1'b0, sc);
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b required 0", bus.o_err);
    end
  endtask

  task automatic test_bad_size(input int bs, input string name);
    beat_cnt = 0;
    bus.i_block_size   = 10'(bs);
    bus.i_siso_data_ab = 2'b01;
    bus.i_siso_buf_wr  = 1'b1;
    @(posedge clk); #1;
    bus.i_siso_buf_wr  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_err, bus.o_busy, bus.o_enc_valid} !== 3'b100 || beat_cnt != 0) begin
      errors++;
      $display("FAIL %s: got err,busy,valid=%b beats=%0d required 100 beats=0", name,
               {bus.o_err, bus.o_busy, bus.o_enc_valid}, beat_cnt);
    end
    do_reset();
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_err_clear: got %b required 0", name, bus.o_err);
    end
  endtask

  task automatic test_strobe_in_pre();
    logic [1:0] p [$];
    logic [2:0] sc;
    for (int i = 0; i < 4; i++) p.push_back(2'($urandom));
    model_push(p, sc);
    run_block("pre_strobe", 1, p, 1'b0, 1'b1, sc);
    checks++;
    if (bus.o_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_strobe_err: got %b required 1", bus.o_err);
    end
  endtask

  task automatic test_reset_mid_enc();
    logic [1:0] p [$];
    logic [2:0] sc;
    int budget;
    for (int i = 0; i < 8; i++) p.push_back(2'($urandom));
    model_push(p, sc);
    beat_cnt = 0;
    write_pairs(2, p, 1'b0);
    budget = 100;
    while (beat_cnt == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    checks++;
    if (beat_cnt == 0) begin
      errors++;
      $display("FAIL mid_enc_timeout: got no beat required a beat within 100 cycles");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_enc_reset");
    rst = 1'b0;
    sb_q.delete();
    p.delete();
    for (int i = 0; i < 4; i++) p.push_back(2'($urandom));
    model_push(p, sc);
    run_block("after_reset", 1, p, 1'b1, 1'b0, sc);
  endtask

  task automatic test_full_size();
    logic [1:0] p [$];
    logic [2:0] sc;
    for (int i = 0; i < 4092; i++) p.push_back(2'($urandom));
    model_push(p, sc);
    run_block("full_size", 1023, p, 1'b0, 1'b0, sc);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_block_size   = '0;
    bus.i_siso_data_ab = '0;
    bus.i_siso_buf_wr  = 1'b0;
    bus.i_out_ready    = 1'b1;
    test_reset();
    test_known_block();
    test_zero_block();
    test_random_ready();
    test_bad_size(7, "size_mod7");
    test_bad_size(0, "size_zero");
    test_strobe_in_pre();
    test_reset_mid_enc();
    test_full_size();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion required finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/turbo_enc_crsc.md
Name: turbo_enc_crsc

Overview:
Duobinary circular recursive systematic convolutional (CRSC) constituent encoder, directly downstream of the turbo encoder address generator.
- Captures the stream of AB pairs plus write strobe into an internal pair buffer.
- Pre-encodes from state 0 to derive the circulation state Sc, then re-encodes from Sc, emitting systematic A/B and parity Y/W with a valid/ready handshake.
- The top level instantiates it twice: natural order and interleaved order.

Parameters:
MAX_BLOCK_WIDTH, 10, width of i_block_size; the block holds N = 4*i_block_size pairs.
MAX_DATA_WIDTH, MAX_BLOCK_WIDTH+2, pair-buffer address width; depth is 2^MAX_DATA_WIDTH.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_block_size  in  MAX_BLOCK_WIDTH  N/4; sampled on the first pair write in IDLE
i_siso_data_ab  in  2  pair {A,B}: bit1 = A, bit0 = B
i_siso_buf_wr  in  1  pair write strobe, one pair per asserted cycle
i_out_ready  in  1  consumer accepts the output pair
o_enc_ab  out  2  systematic pair {A,B}
o_enc_yw  out  2  parity pair {Y,W}
o_enc_valid  out  1  output pair valid
o_enc_done  out  1  one-cycle pulse after the last pair is accepted
o_busy  out  1  high in every state except IDLE
o_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (i_rst high at a clock edge):
  - FSM goes to IDLE; state register and all counters go to 0.
  - o_enc_ab, o_enc_yw, o_enc_valid, o_enc_done, o_busy and o_err all go to 0.
  - Reset mid-operation abandons the block. Buffer contents are don't-care.
- Trellis: state S = {s1,s2,s3}, index = 4*s1+2*s2+s3.
  - fb = A^B^s1^s3
  - Y = fb^s2^s3
  - W = fb^s3
  - Next state: s1' = fb, s2' = s1^B, s3' = s2^B.
- Circulation table CIRC[N mod 7][S0N], rows listed for S0N = 0..7:
  - row 1: 0 6 4 2 7 1 3 5
  - row 2: 0 3 7 4 5 6 2 1
  - row 3: 0 5 3 6 2 7 1 4
  - row 4: 0 4 1 5 6 2 7 3
  - row 5: 0 2 5 7 1 3 4 6
  - row 6: 0 7 6 1 3 4 5 2
- FSM states: IDLE, FILL, PRE, CIRC, ENC, DONE.
- IDLE:
  - On i_siso_buf_wr, latch N = {i_block_size,2'b00}, write the pair to address 0 (wr_cnt = 1), go to FILL.
  - If i_block_size = 0 or N mod 7 = 0: set o_err, drop the pair, stay in IDLE.
- FILL: each strobe writes to address wr_cnt and increments it. When the write at address N-1 occurs, go to PRE in the next cycle.
- PRE:
  - Buffer read latency is 1 cycle.
  - Issue reads for addresses 0..N-1 on consecutive cycles and fold each returned pair into S from state 0.
  - After the N-th pair is folded (N+1 cycles in PRE), S holds S0N; go to CIRC.
- CIRC: one cycle; S <= CIRC[N mod 7][S0N]; rd_cnt <= 0; go to ENC.
- ENC:
  - Prefetch the pair, then present o_enc_ab, o_enc_yw (computed from the current S) with o_enc_valid = 1.
  - Hold all outputs stable while i_out_ready = 0.
  - On valid & ready: update S and present the next pair. No bubble is required when ready stays high; throughput is 1 pair/cycle.
  - After the N-th accept, drop valid and go to DONE.
  - Invariant: the final S equals Sc.
- DONE: o_enc_done = 1 for one cycle, then go to IDLE.
- A strobe outside IDLE/FILL is dropped and sets o_err.
- N mod 7 is computed once at latch time, sequentially or combinationally, registered before PRE ends.
- Counters are MAX_DATA_WIDTH+1 bits, so no wrap is possible at full size (N = 4092 for i_block_size = 1023).

Decomposition:
- Package turbo_enc_pkg:
  - state-index width 3
  - CIRC table constant
  - trellis next-state / parity function
  - FSM state encoding
- One sub-module: turbo_enc_pair_ram.
  - Simple dual-port, 2^MAX_DATA_WIDTH x 2, synchronous write and synchronous 1-cycle read, no reset.

Test Plan:
- block_size=1; pairs 10,00,00,00 -> S0N = 3, Sc = 5; Y sequence 0,0,0,1; W sequence 0,1,1,0; final S = 5; one o_enc_done pulse.
- block_size=1; all pairs 00 -> Sc = 0; Y = W = 0 throughout; 4 valid beats; o_busy low after DONE.
- block_size=2 (N=8, mod 7 = 1); 8 random pairs; i_out_ready toggled randomly -> outputs match the golden model; no beat lost or duplicated; final S = Sc.
- block_size=7 (N = 28, mod 7 = 0) -> o_err = 1; block stays IDLE; no valid.
- Strobe during PRE -> o_err set; encoding unaffected. i_rst asserted mid-ENC -> next cycle all outputs 0; a new block encodes correctly afterwards.
- block_size=1023 (N = 4092, mod 7 = 4); random data; ready held high -> 4092 consecutive valid beats; final S = Sc; o_enc_done once.
